// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter between fetch and data ports.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [2:0] SIZE_DWORD = 3'b011;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data has priority unless fetch has been starved too long.
// Kept standalone so extra requesters (e.g. a page-table walker) can slot in later.
module mem_arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic streak_full,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = d_req && !(i_req && streak_full);
  assign grant_i = i_req && (!d_req || streak_full);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory between fetch and data ports.
// state | meaning
// IDLE  | no transaction; grant a requester and latch its command
// ISSUE | mem_req held with latched fields until mem_ready
// WAIT  | read accepted; latency counter runs down to the data cycle
// RESP  | one-cycle rvalid to the held requester
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [63:0]       d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  output logic [2:0]        mem_size,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STK_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_t        state, state_nxt;
  logic [STK_W-1:0]  streak;
  logic [LAT_W-1:0]  lat_cnt;
  req_id_t           hold_id;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_we;
  logic [63:0]       hold_wdata;
  logic [2:0]        hold_size;
  logic [63:0]       rdata_q;
  logic              streak_full, pick_i, pick_d, grant_i, grant_d, accept;

  assign streak_full = (streak == STK_W'(STARVE_MAX));

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .streak_full (streak_full),
    .grant_i     (pick_i),
    .grant_d     (pick_d)
  );

  assign grant_i = (state == IDLE) && pick_i;
  assign grant_d = (state == IDLE) && pick_d;
  assign accept  = (state == ISSUE) && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_nxt = ISSUE;
      ISSUE:   if (mem_ready) state_nxt = hold_we ? RESP : WAIT;
      WAIT:    if (lat_cnt == LAT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch commands are always word reads; data commands carry their own fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak     <= '0;
      lat_cnt    <= '0;
      hold_id    <= REQ_I;
      hold_addr  <= '0;
      hold_we    <= 1'b0;
      hold_wdata <= '0;
      hold_size  <= '0;
      rdata_q    <= '0;
    end else begin
      if (grant_i || grant_d) begin
        hold_id    <= grant_d ? REQ_D : REQ_I;
        hold_addr  <= grant_d ? d_addr : i_addr;
        hold_we    <= grant_d && d_we;
        hold_wdata <= grant_d ? d_wdata : 64'd0;
        hold_size  <= grant_d ? d_size : SIZE_WORD;
        if (grant_i || !i_req) streak <= '0;
        else if (!streak_full) streak <= streak + 1'b1;
      end
      if (accept && !hold_we) begin
        lat_cnt <= LAT_W'(MEM_LAT);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_cnt == LAT_W'(1)) rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    i_gnt     = grant_i;
    d_gnt     = grant_d;
    busy      = (state != IDLE);
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_size  = '0;
    case (state)
      ISSUE: begin
        mem_req   = 1'b1;
        mem_addr  = hold_addr;
        mem_we    = hold_we;
        mem_wdata = hold_wdata;
        mem_size  = hold_size;
      end
      RESP: begin
        if (hold_id == REQ_I) begin
          i_rvalid = 1'b1;
          i_rdata  = hold_addr[2] ? rdata_q[63:32] : rdata_q[31:0];
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = hold_we ? 64'd0 : rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: transaction-timestamp model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_riscv_mem_arbiter;

  localparam int ADDR_W     = 64;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [63:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic [63:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [63:0] d_wdata = '0;
  logic [2:0]  d_size = '0;
  logic        mem_ready = 1'b1;
  logic [63:0] mem_rdata;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [31:0] i_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_size;

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Memory responder: read data only appears exactly MEM_LAT cycles after acceptance.
  logic [63:0] rd_word  = '0;
  int          resp_acc = -100;
  assign mem_rdata = (cyc == resp_acc + MEM_LAT) ? rd_word : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: one transaction tracked by cycle timestamps.
  bit          m_free = 1'b1;
  int          m_streak = 0;
  bit          m_acc = 1'b0;
  int          m_acc_cyc = 0;
  int          m_resp = 0;
  bit          t_d = 1'b0;
  bit          t_we = 1'b0;
  logic [63:0] t_addr = '0;
  logic [63:0] t_wdata = '0;
  logic [2:0]  t_size = '0;
  logic [63:0] m_data = '0;

  always @(negedge clk) begin : compare_model
    bit          full, e_ig, e_dg, e_mreq, e_irv, e_drv;
    logic [31:0] e_irdata;
    logic [63:0] e_drdata;
    full     = (m_streak == STARVE_MAX);
    e_ig     = m_free && i_req && (!d_req || full);
    e_dg     = m_free && d_req && !(i_req && full);
    e_mreq   = !m_free && !m_acc;
    e_irv    = !m_free && m_acc && (cyc == m_resp) && !t_d;
    e_drv    = !m_free && m_acc && (cyc == m_resp) && t_d;
    e_irdata = e_irv ? (t_addr[2] ? m_data[63:32] : m_data[31:0]) : 32'd0;
    e_drdata = (e_drv && !t_we) ? m_data : 64'd0;
    if (chk_en) begin
      check("busy", 64'(busy), 64'(!m_free));
      check("i_gnt", 64'(i_gnt), 64'(e_ig));
      check("d_gnt", 64'(d_gnt), 64'(e_dg));
      check("mem_req", 64'(mem_req), 64'(e_mreq));
      check("mem_addr", mem_addr, e_mreq ? t_addr : 64'd0);
      check("mem_we", 64'(mem_we), 64'(e_mreq && t_we));
      check("mem_wdata", mem_wdata, e_mreq ? t_wdata : 64'd0);
      check("mem_size", 64'(mem_size), e_mreq ? 64'(t_size) : 64'd0);
      check("i_rvalid", 64'(i_rvalid), 64'(e_irv));
      check("i_rdata", 64'(i_rdata), 64'(e_irdata));
      check("d_rvalid", 64'(d_rvalid), 64'(e_drv));
      check("d_rdata", d_rdata, e_drdata);
    end
    if (mem_req && mem_ready) resp_acc = cyc;
    if (!m_free) begin
      if (m_acc && cyc == m_resp) m_free = 1'b1;
      if (m_acc && !t_we && cyc == m_acc_cyc + MEM_LAT) m_data = mem_rdata;
      if (!m_acc && mem_ready) begin
        m_acc     = 1'b1;
        m_acc_cyc = cyc;
        m_resp    = t_we ? cyc + 1 : cyc + MEM_LAT + 1;
      end
    end else if (e_dg) begin
      t_d = 1'b1; t_addr = d_addr; t_we = d_we; t_wdata = d_wdata; t_size = d_size;
      m_streak = i_req ? ((m_streak < STARVE_MAX) ? m_streak + 1 : m_streak) : 0;
      m_free = 1'b0; m_acc = 1'b0;
    end else if (e_ig) begin
      t_d = 1'b0; t_addr = i_addr; t_we = 1'b0; t_wdata = '0; t_size = 3'b010;
      m_streak = 0;
      m_free = 1'b0; m_acc = 1'b0;
    end
    if (rst) begin
      m_free = 1'b1; m_streak = 0; m_acc = 1'b0; m_data = '0;
      chk_en = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  logic [63:0] a6 [2] = '{64'h8, 64'hC};
  logic [31:0] e6 [2] = '{32'h2222_2222, 32'h1111_1111};
  string       order;

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_rvalid", 64'(i_rvalid | d_rvalid), 64'd0);
    check("rst_gnt", 64'(i_gnt | d_gnt), 64'd0);

    // Single fetch read.
    step();
    rd_word = 64'hDEAD_BEEF_0000_0013; i_req = 1'b1; i_addr = 64'h4;
    #2; check("t1_i_gnt", 64'(i_gnt), 64'd1);
    step(); i_req = 1'b0;
    #2; check("t1_mem_req", 64'(mem_req), 64'd1);
    check("t1_mem_addr", mem_addr, 64'h4);
    check("t1_mem_size", 64'(mem_size), 64'd2);
    step(); #2; check("t1_early_rv2", 64'(i_rvalid), 64'd0);
    step(); #2; check("t1_early_rv3", 64'(i_rvalid), 64'd0);
    step(); #2; check("t1_i_rvalid", 64'(i_rvalid), 64'd1);
    check("t1_i_rdata", 64'(i_rdata), 64'hDEAD_BEEF);
    step(); #2; check("t1_idle", 64'(busy), 64'd0);

    // Data write with two cycles of back-pressure.
    step();
    rd_word = 64'hFFFF_FFFF_FFFF_FFFF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'h55; d_size = 3'd3; mem_ready = 1'b0;
    #2; check("t2_d_gnt", 64'(d_gnt), 64'd1);
    step(); d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b1;
      #2;
      check("t2_mem_req", 64'(mem_req), 64'd1);
      check("t2_mem_addr", mem_addr, 64'h100);
      check("t2_mem_wdata", mem_wdata, 64'h55);
      check("t2_mem_we", 64'(mem_we), 64'd1);
      check("t2_no_rv", 64'(d_rvalid), 64'd0);
      step();
    end
    #2; check("t2_d_rvalid", 64'(d_rvalid), 64'd1);
    check("t2_d_rdata", d_rdata, 64'd0);
    step(); #2; check("t2_idle", 64'(busy), 64'd0);

    // Both requesters held: fetch gets every fifth grant.
    step();
    order = "";
    i_req = 1'b1; i_addr = 64'h10; rd_word = 64'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = 64'h1; d_size = 3'd3;
    for (int k = 0; k < 200 && order.len() < 10; k++) begin
      #2;
      if (d_gnt) order = {order, "D"};
      else if (i_gnt) order = {order, "I"};
      step();
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    n_checks++;
    if (order != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL t3_grant_order: got %s expected DDDDIDDDDI", order);
    end
    repeat (6) step();

    // Requests arriving during WAIT are held off until IDLE; data wins.
    rd_word = 64'h0123_4567_89AB_CDEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200; d_size = 3'd3;
    #2; check("t4_d_gnt", 64'(d_gnt), 64'd1);
    step(); d_req = 1'b0;
    step();
    i_req = 1'b1; i_addr = 64'h20; d_req = 1'b1; d_we = 1'b1; d_addr = 64'h300; d_wdata = 64'h77;
    #2; check("t4_hold_gnt_w1", 64'({i_gnt, d_gnt}), 64'd0);
    step(); #2; check("t4_hold_gnt_w2", 64'({i_gnt, d_gnt}), 64'd0);
    step(); #2; check("t4_hold_gnt_resp", 64'({i_gnt, d_gnt}), 64'd0);
    check("t4_d_rvalid", 64'(d_rvalid), 64'd1);
    check("t4_d_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
    step(); #2; check("t4_d_first", 64'(d_gnt), 64'd1);
    check("t4_i_later", 64'(i_gnt), 64'd0);
    step(); i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (6) step();

    // Reset while waiting for read data drops the transaction.
    rd_word = 64'hCAFE_F00D_CAFE_F00D;
    i_req = 1'b1; i_addr = 64'h8;
    #2; check("t5_i_gnt", 64'(i_gnt), 64'd1);
    step(); i_req = 1'b0;
    step(); rst = 1'b1;
    #2; check("t5_busy_wait", 64'(busy), 64'd1);
    step(); rst = 1'b0;
    #2; check("t5_busy", 64'(busy), 64'd0);
    check("t5_mem_req", 64'(mem_req), 64'd0);
    check("t5_mem_addr", mem_addr, 64'd0);
    check("t5_i_rdata", 64'(i_rdata), 64'd0);
    for (int k = 0; k < 6; k++) begin
      check("t5_no_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
      step(); #2;
    end

    // Fetch word selection by address bit 2.
    for (int k = 0; k < 2; k++) begin
      step();
      rd_word = 64'h1111_1111_2222_2222; i_req = 1'b1; i_addr = a6[k];
      #2; check("t6_i_gnt", 64'(i_gnt), 64'd1);
      step(); i_req = 1'b0;
      repeat (3) step();
      #2; check("t6_i_rvalid", 64'(i_rvalid), 64'd1);
      check("t6_i_rdata", 64'(i_rdata), 64'(e6[k]));
      step();
    end

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
